// File: rtl/cmos_pkg.sv
// Shared types and default widths for the DVP capture path and the frame-buffer writer.
package cmos_pkg;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    SKIP    = 2'd1,
    IDLE    = 2'd2,
    RUN     = 2'd3
  } cmos_state_e;

  localparam int CMOS_IN_W   = 8;
  localparam int CMOS_BEATS  = 2;
  localparam int CMOS_OUT_W  = CMOS_IN_W * CMOS_BEATS;
  localparam int CMOS_CNT_W  = 12;
  localparam int CMOS_SKIP_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmos_beat_assembler.sv
// Collects BEATS narrow camera beats into one wide word; word_valid_o marks the completing beat.
module cmos_beat_assembler
  import cmos_pkg::*;
#(
  parameter int IN_W      = CMOS_IN_W,
  parameter int BEATS     = CMOS_BEATS,
  parameter int MSB_FIRST = 1
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  beat_valid_i,
  input  logic                  flush_i,
  input  logic [IN_W-1:0]       pdata_i,
  output logic                  word_valid_o,
  output logic [IN_W*BEATS-1:0] word_o,
  output logic                  partial_o
);

  localparam int OUT_W = IN_W * BEATS;
  localparam int CW    = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [OUT_W-1:0] slot_q;
  logic [OUT_W-1:0] slot_d;
  logic             last;

  function automatic int slot_lsb(input int k);
    return (MSB_FIRST != 0) ? (BEATS - 1 - k) * IN_W : k * IN_W;
  endfunction

  // The current beat is merged combinationally so the final beat never waits a cycle.
  always_comb begin
    word_o = slot_q;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == CW'(k)) word_o[slot_lsb(k) +: IN_W] = pdata_i;
    end
  end

  assign last         = (cnt_q == LAST);
  assign word_valid_o = beat_valid_i & last;
  assign partial_o    = (cnt_q != '0);

  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (beat_valid_i) begin
      cnt_d  = last ? '0 : cnt_q + 1'b1;
      slot_d = word_o;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Slot contents are always overwritten before use, so they carry no reset.
  always_ff @(posedge pclk) begin
    slot_q <= slot_d;
  end

endmodule

// File: rtl/cmos_pixel_packer.sv
// DVP capture front end: frame-aligned enable, startup frame skip, beat packing,
// pixel/line coordinates, line-length reporting and partial-pixel detection.
module cmos_pixel_packer
  import cmos_pkg::*;
#(
  parameter int IN_W        = CMOS_IN_W,
  parameter int BEATS       = CMOS_BEATS,
  parameter int MSB_FIRST   = 1,
  parameter int VS_POL      = 1,
  parameter int SKIP_FRAMES = 2,
  parameter int CNT_W       = CMOS_CNT_W
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  vs_i,
  input  logic                  de_i,
  input  logic [IN_W-1:0]       pdata_i,
  input  logic                  cap_en_i,
  input  logic                  err_clr_i,
  output logic                  de_o,
  output logic [IN_W*BEATS-1:0] pdata_o,
  output logic                  sof_o,
  output logic [CNT_W-1:0]      x_o,
  output logic [CNT_W-1:0]      y_o,
  output logic                  line_done_o,
  output logic [CNT_W-1:0]      line_len_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  err_partial_o,
  output logic                  err_sticky_o
);

  localparam int OUT_W = IN_W * BEATS;
  localparam logic [CNT_W-1:0]       CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CMOS_SKIP_W-1:0] SKIP_INIT = CMOS_SKIP_W'(SKIP_FRAMES);

  cmos_state_e            state_q;
  cmos_state_e            state_d;
  logic [CMOS_SKIP_W-1:0] skip_q;
  logic [CMOS_SKIP_W-1:0] skip_d;
  logic                   vs_q;

  logic                   de_prev_q;
  logic                   de_prev_d;
  logic                   sof_pend_q;
  logic                   sof_pend_d;
  logic [CNT_W-1:0]       pix_cnt_q;
  logic [CNT_W-1:0]       pix_cnt_d;
  logic [CNT_W-1:0]       line_cnt_q;
  logic [CNT_W-1:0]       line_cnt_d;

  logic                   de_q;
  logic                   de_d;
  logic [OUT_W-1:0]       pdata_q;
  logic [OUT_W-1:0]       pdata_d;
  logic                   sof_q;
  logic                   sof_d;
  logic [CNT_W-1:0]       x_q;
  logic [CNT_W-1:0]       x_d;
  logic [CNT_W-1:0]       y_q;
  logic [CNT_W-1:0]       y_d;
  logic                   line_done_q;
  logic                   line_done_d;
  logic [CNT_W-1:0]       line_len_q;
  logic [CNT_W-1:0]       line_len_d;
  logic [15:0]            frame_cnt_q;
  logic [15:0]            frame_cnt_d;
  logic                   err_partial_q;
  logic                   err_partial_d;
  logic                   err_sticky_q;
  logic                   err_sticky_d;

  logic                   fs;
  logic                   frame_start;
  logic                   beat_valid;
  logic                   line_end;
  logic                   flush;
  logic                   word_valid;
  logic [OUT_W-1:0]       word;
  logic                   partial;

  assign fs = (VS_POL != 0) ? (vs_i & ~vs_q) : (~vs_i & vs_q);

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    if (fs) begin
      case (state_q)
        WAIT_VS: begin
          if (skip_q != '0)  state_d = SKIP;
          else if (cap_en_i) state_d = RUN;
          else               state_d = IDLE;
        end
        SKIP: begin
          if (skip_q <= CMOS_SKIP_W'(1)) begin
            skip_d  = '0;
            state_d = cap_en_i ? RUN : IDLE;
          end else begin
            skip_d = skip_q - 1'b1;
          end
        end
        RUN:     if (!cap_en_i) state_d = IDLE;
        IDLE:    if (cap_en_i)  state_d = RUN;
        default: state_d = WAIT_VS;
      endcase
    end
  end

  // A frame edge overrides any beat or line end arriving in the same cycle.
  assign frame_start = fs & (state_d == RUN);
  assign beat_valid  = (state_q == RUN) & de_i & ~fs;
  assign line_end    = de_prev_q & ~de_i & ~fs;
  assign flush       = fs | line_end;

  cmos_beat_assembler #(
    .IN_W      (IN_W),
    .BEATS     (BEATS),
    .MSB_FIRST (MSB_FIRST)
  ) u_asm (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .beat_valid_i (beat_valid),
    .flush_i      (flush),
    .pdata_i      (pdata_i),
    .word_valid_o (word_valid),
    .word_o       (word),
    .partial_o    (partial)
  );

  always_comb begin
    de_prev_d     = beat_valid;
    sof_pend_d    = sof_pend_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    de_d          = 1'b0;
    pdata_d       = pdata_q;
    sof_d         = 1'b0;
    x_d           = x_q;
    y_d           = y_q;
    line_done_d   = 1'b0;
    line_len_d    = line_len_q;
    frame_cnt_d   = frame_cnt_q;
    err_partial_d = 1'b0;
    err_sticky_d  = err_sticky_q & ~err_clr_i;

    if (frame_start) begin
      pix_cnt_d   = '0;
      line_cnt_d  = '0;
      sof_pend_d  = 1'b1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      if (word_valid) begin
        de_d       = 1'b1;
        pdata_d    = word;
        sof_d      = sof_pend_q;
        sof_pend_d = 1'b0;
        x_d        = pix_cnt_q;
        y_d        = line_cnt_q;
        if (pix_cnt_q != CNT_MAX) pix_cnt_d = pix_cnt_q + 1'b1;
      end
      // A new error outranks a clear in the same cycle.
      if (line_end) begin
        line_done_d = 1'b1;
        line_len_d  = pix_cnt_q;
        pix_cnt_d   = '0;
        if (line_cnt_q != CNT_MAX) line_cnt_d = line_cnt_q + 1'b1;
        if (partial) begin
          err_partial_d = 1'b1;
          err_sticky_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_VS;
      skip_q        <= SKIP_INIT;
      vs_q          <= 1'b0;
      de_prev_q     <= 1'b0;
      sof_pend_q    <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      de_q          <= 1'b0;
      pdata_q       <= '0;
      sof_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_done_q   <= 1'b0;
      line_len_q    <= '0;
      frame_cnt_q   <= '0;
      err_partial_q <= 1'b0;
      err_sticky_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_q        <= skip_d;
      vs_q          <= vs_i;
      de_prev_q     <= de_prev_d;
      sof_pend_q    <= sof_pend_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      de_q          <= de_d;
      pdata_q       <= pdata_d;
      sof_q         <= sof_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_done_q   <= line_done_d;
      line_len_q    <= line_len_d;
      frame_cnt_q   <= frame_cnt_d;
      err_partial_q <= err_partial_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  assign de_o          = de_q;
  assign pdata_o       = pdata_q;
  assign sof_o         = sof_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign line_done_o   = line_done_q;
  assign line_len_o    = line_len_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign err_partial_o = err_partial_q;
  assign err_sticky_o  = err_sticky_q;

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Scoreboard bench: two packer instances (default 2-beat MSB-first, and 3-beat LSB-first with no skip).
module tb_cmos_pixel_packer;

  typedef struct {
    logic [23:0] data;
    logic        sof;
    logic [11:0] x;
    logic [11:0] y;
    int          cyc;
  } pix_t;

  typedef struct {
    logic [11:0] len;
    logic        part;
  } ln_t;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  logic        vs_a, de_a, cap_a, clr_a;
  logic [7:0]  pd_a;
  logic        de_o_a, sof_a, ld_a, ep_a, es_a;
  logic [15:0] pd_o_a;
  logic [11:0] x_a, y_a, len_a;
  logic [15:0] fc_a;

  logic        vs_b, de_b, cap_b, clr_b;
  logic [7:0]  pd_b;
  logic        de_o_b, sof_b, ld_b, ep_b, es_b;
  logic [23:0] pd_o_b;
  logic [11:0] x_b, y_b, len_b;
  logic [15:0] fc_b;

  cmos_pixel_packer dut (
    .pclk(pclk), .rst_n(rst_n), .vs_i(vs_a), .de_i(de_a), .pdata_i(pd_a),
    .cap_en_i(cap_a), .err_clr_i(clr_a), .de_o(de_o_a), .pdata_o(pd_o_a),
    .sof_o(sof_a), .x_o(x_a), .y_o(y_a), .line_done_o(ld_a), .line_len_o(len_a),
    .frame_cnt_o(fc_a), .err_partial_o(ep_a), .err_sticky_o(es_a)
  );

  cmos_pixel_packer #(
    .IN_W(8), .BEATS(3), .MSB_FIRST(0), .VS_POL(1), .SKIP_FRAMES(0), .CNT_W(12)
  ) dut3 (
    .pclk(pclk), .rst_n(rst_n), .vs_i(vs_b), .de_i(de_b), .pdata_i(pd_b),
    .cap_en_i(cap_b), .err_clr_i(clr_b), .de_o(de_o_b), .pdata_o(pd_o_b),
    .sof_o(sof_b), .x_o(x_b), .y_o(y_b), .line_done_o(ld_b), .line_len_o(len_b),
    .frame_cnt_o(fc_b), .err_partial_o(ep_b), .err_sticky_o(es_b)
  );

  int checks = 0;
  int errors = 0;

  pix_t pq_a[$];
  pix_t pq_b[$];
  ln_t  lq_a[$];
  ln_t  lq_b[$];
  pix_t mp_a, mp_b;
  ln_t  ml_a, ml_b;
  logic [7:0] bv [8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: every strobe must match the head of the expectation queue.
  always @(negedge pclk) begin
    if (rst_n) begin
      if (de_o_a) begin
        if (pq_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL pix_a: unexpected de_o with pdata=0x%0h, expected no pixel", pd_o_a);
        end else begin
          mp_a = pq_a.pop_front();
          chk("pix_a_data", pd_o_a, mp_a.data);
          chk("pix_a_sof", sof_a, mp_a.sof);
          chk("pix_a_x", x_a, mp_a.x);
          chk("pix_a_y", y_a, mp_a.y);
          chk("pix_a_cycle", cyc, mp_a.cyc);
        end
      end
      if (ld_a) begin
        if (lq_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL line_a: unexpected line_done len=%0d, expected none", len_a);
        end else begin
          ml_a = lq_a.pop_front();
          chk("line_a_len", len_a, ml_a.len);
          chk("line_a_partial", ep_a, ml_a.part);
        end
      end else if (ep_a) begin
        checks++; errors++;
        $display("FAIL errp_a: err_partial_o=1 without line_done, expected 0");
      end
    end
  end

  always @(negedge pclk) begin
    if (rst_n) begin
      if (de_o_b) begin
        if (pq_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL pix_b: unexpected de_o with pdata=0x%0h, expected no pixel", pd_o_b);
        end else begin
          mp_b = pq_b.pop_front();
          chk("pix_b_data", pd_o_b, mp_b.data);
          chk("pix_b_sof", sof_b, mp_b.sof);
          chk("pix_b_x", x_b, mp_b.x);
          chk("pix_b_y", y_b, mp_b.y);
          chk("pix_b_cycle", cyc, mp_b.cyc);
        end
      end
      if (ld_b) begin
        if (lq_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL line_b: unexpected line_done len=%0d, expected none", len_b);
        end else begin
          ml_b = lq_b.pop_front();
          chk("line_b_len", len_b, ml_b.len);
          chk("line_b_partial", ep_b, ml_b.part);
        end
      end else if (ep_b) begin
        checks++; errors++;
        $display("FAIL errp_b: err_partial_o=1 without line_done, expected 0");
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_de(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin de_a = v; pd_a = d; end
    else          begin de_b = v; pd_b = d; end
  endtask

  task automatic set_vs(input int sel, input logic v);
    if (sel == 0) vs_a = v; else vs_b = v;
  endtask

  task automatic set_clr(input int sel, input logic v);
    if (sel == 0) clr_a = v; else clr_b = v;
  endtask

  task automatic frame_edge(input int sel);
    set_vs(sel, 1'b1); tick(); tick();
    set_vs(sel, 1'b0); tick(); tick();
  endtask

  task automatic push_pix(input int sel, input logic [23:0] d, input logic s,
                          input int x, input logic [11:0] y);
    pix_t p;
    p.data = d; p.sof = s; p.x = 12'(x); p.y = y; p.cyc = cyc + 1;
    if (sel == 0) pq_a.push_back(p); else pq_b.push_back(p);
  endtask

  // Drives n beats; expected words follow the bus order of each instance.
  task automatic send_line(input int sel, input int n, input logic [7:0] b [8], input bit cap,
                           input logic [11:0] y, input bit sof_first, input bit clr_end);
    int   nb;
    int   px;
    ln_t  l;
    logic [23:0] w;
    nb = (sel == 0) ? 2 : 3;
    px = 0;
    for (int j = 0; j < n; j++) begin
      set_de(sel, 1'b1, b[j]);
      if (cap && (j % nb == nb - 1)) begin
        if (sel == 0) w = {8'h00, b[j-1], b[j]};
        else          w = {b[j], b[j-1], b[j-2]};
        push_pix(sel, w, sof_first && (px == 0), px, y);
        px++;
      end
      tick();
    end
    set_de(sel, 1'b0, 8'h00);
    if (clr_end) set_clr(sel, 1'b1);
    if (cap) begin
      l.len = 12'(n / nb);
      l.part = (n % nb) != 0;
      if (sel == 0) lq_a.push_back(l); else lq_b.push_back(l);
    end
    tick();
    set_clr(sel, 1'b0);
    tick();
  endtask

  task automatic std_line(input bit cap, input logic [11:0] y, input bit sof_first, input int l);
    for (int p = 0; p < 4; p++) begin
      bv[2*p]   = 8'(8'h12 + 34 * (l * 4 + p));
      bv[2*p+1] = 8'(8'h34 + 34 * (l * 4 + p));
    end
    send_line(0, 8, bv, cap, y, sof_first, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    vs_a = 0; de_a = 0; pd_a = 0; cap_a = 1; clr_a = 0;
    vs_b = 0; de_b = 0; pd_b = 0; cap_b = 1; clr_b = 0;
    for (int i = 0; i < 8; i++) bv[i] = 8'h00;
    tick(); tick();
    chk("rst_de", de_o_a, 0);
    chk("rst_pdata", pd_o_a, 0);
    chk("rst_sof", sof_a, 0);
    chk("rst_x", x_a, 0);
    chk("rst_y", y_a, 0);
    chk("rst_line_done", ld_a, 0);
    chk("rst_line_len", len_a, 0);
    chk("rst_frame_cnt", fc_a, 0);
    chk("rst_err_partial", ep_a, 0);
    chk("rst_err_sticky", es_a, 0);
    chk("rst_b_de", de_o_b, 0);
    rst_n = 1'b1;
    tick(); tick();

    // 3-beat LSB-first instance, no skipped frames
    frame_edge(1);
    chk("b_frame_cnt", fc_b, 1);
    bv[0] = 8'hAA; bv[1] = 8'hBB; bv[2] = 8'hCC; bv[3] = 8'h11; bv[4] = 8'h22; bv[5] = 8'h33;
    send_line(1, 6, bv, 1'b1, 12'd0, 1'b1, 1'b0);
    bv[0] = 8'h44; bv[1] = 8'h55; bv[2] = 8'h66; bv[3] = 8'h77;
    send_line(1, 4, bv, 1'b1, 12'd1, 1'b0, 1'b0);
    chk("b_err_sticky", es_b, 1);

    // Default instance: two skipped frames, then capture
    for (int f = 1; f <= 4; f++) begin
      frame_edge(0);
      if (f == 2) chk("a_frame_cnt_skip", fc_a, 0);
      if (f == 3) chk("a_frame_cnt_f3", fc_a, 1);
      if (f == 4) chk("a_frame_cnt_f4", fc_a, 2);
      for (int l = 0; l < 2; l++) std_line(f >= 3, 12'(l), l == 0, l);
    end
    chk("a_sticky_clean", es_a, 0);

    for (int i = 0; i < 7; i++) bv[i] = 8'(8'hA0 + i);
    send_line(0, 7, bv, 1'b1, 12'd2, 1'b0, 1'b0);
    chk("a_sticky_set", es_a, 1);
    bv[0] = 8'hB0; bv[1] = 8'hB1; bv[2] = 8'hB2;
    send_line(0, 3, bv, 1'b1, 12'd3, 1'b0, 1'b1);
    chk("a_sticky_err_beats_clr", es_a, 1);
    clr_a = 1'b1; tick(); clr_a = 1'b0; tick();
    chk("a_sticky_cleared", es_a, 0);

    // Capture enable only acts at frame edges
    frame_edge(0);
    chk("a_frame_cnt_f5", fc_a, 3);
    std_line(1'b1, 12'd0, 1'b1, 0);
    cap_a = 1'b0;
    std_line(1'b1, 12'd1, 1'b0, 1);
    frame_edge(0);
    chk("a_frame_cnt_idle", fc_a, 3);
    std_line(1'b0, 12'd0, 1'b0, 0);
    cap_a = 1'b1;
    std_line(1'b0, 12'd1, 1'b0, 1);
    frame_edge(0);
    chk("a_frame_cnt_rerun", fc_a, 4);
    std_line(1'b1, 12'd0, 1'b1, 2);

    // Frame edge landing on the second beat of a pixel aborts it
    set_de(0, 1'b1, 8'h55); tick();
    set_de(0, 1'b1, 8'h66); vs_a = 1'b1; tick();
    set_de(0, 1'b0, 8'h00); tick();
    vs_a = 1'b0; tick(); tick();
    chk("a_frame_cnt_abort", fc_a, 5);
    std_line(1'b1, 12'd0, 1'b1, 1);

    // Asynchronous reset in the middle of a line
    set_de(0, 1'b1, 8'h77); tick();
    set_de(0, 1'b1, 8'h88); push_pix(0, 24'h007788, 1'b0, 0, 12'd1); tick();
    set_de(0, 1'b1, 8'h99); tick();
    set_de(0, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pdata", pd_o_a, 0);
    chk("mid_rst_y", y_a, 0);
    chk("mid_rst_frame_cnt", fc_a, 0);
    chk("mid_rst_b_sticky", es_b, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    frame_edge(0);
    std_line(1'b0, 12'd0, 1'b0, 0);
    frame_edge(0);
    std_line(1'b0, 12'd0, 1'b0, 1);
    frame_edge(0);
    chk("post_rst_frame_cnt", fc_a, 1);
    std_line(1'b1, 12'd0, 1'b1, 3);

    repeat (5) tick();
    chk("pix_a_pending", pq_a.size(), 0);
    chk("line_a_pending", lq_a.size(), 0);
    chk("pix_b_pending", pq_b.size(), 0);
    chk("line_b_pending", lq_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmos_pixel_packer.md
Name: cmos_pixel_packer

Overview:
Parametrised successor of the 8-to-16-bit camera bus packer. It assembles BEATS narrow DVP beats into one wide pixel and emits it on a pclk-domain strobe. Adds frame-aligned capture enable, startup frame skipping, pixel and line coordinates, and line-length reporting. It also detects partial pixels. Sits between the camera pads/IO registers and the frame-buffer write path.

Parameters:
IN_W, 8, camera data bus width in bits (1..16)
BEATS, 2, input beats per output pixel (1..4); OUT_W = IN_W*BEATS
MSB_FIRST, 1, 1: first beat lands in the top IN_W bits; 0: first beat in the bottom bits
VS_POL, 1, 1: frame starts on vs_i rising edge; 0: on falling edge
SKIP_FRAMES, 2, number of complete frames discarded after reset (0..15)
CNT_W, 12, width of x/y/line-length counters

Ports:
pclk  in  1  camera pixel clock; all logic in this domain
rst_n  in  1  asynchronous active-low reset
vs_i  in  1  camera vertical sync
de_i  in  1  camera data valid / href
pdata_i  in  IN_W  camera data beat
cap_en_i  in  1  capture enable; sampled only at frame-start edges
err_clr_i  in  1  clears err_sticky_o
de_o  out  1  one-cycle pixel strobe
pdata_o  out  OUT_W  assembled pixel, valid while de_o=1
sof_o  out  1  qualifies de_o: first pixel of a frame
x_o  out  CNT_W  column of the pixel on pdata_o
y_o  out  CNT_W  line of the pixel on pdata_o
line_done_o  out  1  one-cycle pulse after each captured line ends
line_len_o  out  CNT_W  pixel count of the line; valid with line_done_o
frame_cnt_o  out  16  number of captured frames started, wraps
err_partial_o  out  1  one-cycle pulse: line ended mid-pixel
err_sticky_o  out  1  latched err_partial_o

Behaviour:
- Reset: all outputs are 0, state is WAIT_VS, beat counter is 0, and the skip counter is loaded with SKIP_FRAMES.
- Frame-start edge (fs): vs_d registered. fs = vs_i & ~vs_d when VS_POL=1, ~vs_i & vs_d when VS_POL=0.
- FSM:
  - WAIT_VS: on fs, go to SKIP if skip count > 0, else RUN if cap_en_i=1, else IDLE.
  - SKIP: on fs, decrement the skip counter. When it reaches 0, go to RUN or IDLE according to cap_en_i.
  - RUN: on fs, go to IDLE if cap_en_i=0; otherwise stay in RUN.
  - IDLE: on fs, go to RUN if cap_en_i=1.
- Only RUN assembles pixels. De beats in any other state are ignored, and no outputs fire except that frame_cnt_o is untouched.
- Every fs into or within RUN: beat counter, x and y are cleared, frame_cnt_o increments, and the first pixel of that frame carries sof_o=1.
- Assembly: each de_i=1 cycle in RUN stores one beat at the slot given by MSB_FIRST and increments the beat counter. On beat BEATS-1, the next cycle has de_o=1 and pdata_o = assembled word; latency is 1 cycle after the final beat. x increments after each emitted pixel.
- BEATS=1: de_o follows de_i by one cycle, and pdata_o is pdata_i delayed by one cycle.
- pdata_o, x_o, y_o and sof_o hold their values between strobes. de_o and sof_o return to 0 the cycle after the strobe.
- Line end: de_d & ~de_i in RUN. In the next cycle:
  - line_done_o=1 and line_len_o = pixels emitted on that line.
  - y increments and x clears.
  - If beat counter ≠ 0, the partial pixel is discarded, err_partial_o=1, err_sticky_o is set, and the beat counter clears.
- fs simultaneous with de_i=1: fs wins. The beat is discarded, counters are cleared, and no line_done_o fires for the aborted line.
- err_clr_i and a new error in the same cycle: the error wins, so err_sticky_o stays 1.
- x, y and line length saturate at 2^CNT_W-1 and do not wrap.
- Asynchronous reset mid-line: everything returns to WAIT_VS. The first frame after reset is never partially captured.

Decomposition:
- Shared package cmos_pkg holds:
  - the state enum (WAIT_VS, SKIP, IDLE, RUN);
  - function clog2 for the beat counter width;
  - the default width constants shared with the frame-buffer writer.
- One sub-module, cmos_beat_assembler, holds the beat counter and slot register. Its ports are IN_W, BEATS and MSB_FIRST, plus beat_valid, flush, word_valid and partial flags. The top level keeps the FSM, edge detection, counters and errors.

Test Plan:
- Defaults (IN_W=8, BEATS=2, SKIP_FRAMES=2), 4 frames of 2 lines × 4 pixels with beats 0x12,0x34 and so on:
  - frames 1–2 produce no de_o;
  - frame 3's first pixel is 0x1234 with sof_o=1, x=0, y=0, one cycle after beat 0x34;
  - line_done_o fires with line_len_o=4;
  - frame_cnt_o reaches 2 after frame 4 starts.
- MSB_FIRST=0, BEATS=3, beats AA,BB,CC: pdata_o=0xCCBBAA, and de_o occurs every 3rd beat.
- Line of 7 beats with BEATS=2: 3 pixels, line_len_o=3, err_partial_o pulse, err_sticky_o=1 until err_clr_i.
- cap_en_i deasserted mid-frame: the current frame completes. From the next fs there is no de_o and frame_cnt_o holds. cap_en_i reasserted mid-frame takes effect only at the following fs.
- fs injected while de_i=1 after a single beat: no pixel emitted, no line_done_o, and the next frame's first pixel has x=0, y=0, sof_o=1.
- rst_n asserted mid-line: all outputs 0 immediately. After release, pixels appear only after SKIP_FRAMES+1 frame edges.
